// File: rtl/color_switch_ctrl.sv
// Switch/button front end for the VGA colour stage: synchronize, debounce, and pick the colour.
// Define COLOR_CYCLE_EN to build the push-button colour-cycling mode; without it the colour follows sw.
module color_switch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw,
  input  logic       btn,
  output logic       red_out,
  output logic       green_out,
  output logic       blue_out,
  output logic       mode_cycle
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Switch path: two-flop synchronizer followed by a per-bit debouncer
  logic [2:0]       sw_meta_q, sw_sync_q;
  logic [2:0]       sw_stable_q, sw_stable_d;
  logic [CNT_W-1:0] sw_cnt_q [3];
  logic [CNT_W-1:0] sw_cnt_d [3];

  always_comb begin
    sw_stable_d = sw_stable_q;
    for (int i = 0; i < 3; i++) begin
      sw_cnt_d[i] = sw_cnt_q[i];
      if (sw_sync_q[i] == sw_stable_q[i]) begin
        sw_cnt_d[i] = '0;
      end else if (sw_cnt_q[i] == CNT_MAX) begin
        sw_stable_d[i] = sw_sync_q[i];
        sw_cnt_d[i]    = '0;
      end else begin
        sw_cnt_d[i] = sw_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sw_stable_q <= '0;
      for (int i = 0; i < 3; i++) sw_cnt_q[i] <= '0;
    end else begin
      sw_meta_q   <= sw;
      sw_sync_q   <= sw_meta_q;
      sw_stable_q <= sw_stable_d;
      for (int i = 0; i < 3; i++) sw_cnt_q[i] <= sw_cnt_d[i];
    end
  end

  logic [2:0] colour_d, colour_q;

`ifdef COLOR_CYCLE_EN
  typedef enum logic {DIRECT = 1'b0, CYCLE = 1'b1} state_e;

  logic             btn_meta_q, btn_sync_q;
  logic             btn_stable_q, btn_stable_d;
  logic             btn_prev_q;
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
  logic [2:0]       sw_prev_q;
  logic             btn_rise, sw_chg;
  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;

  always_comb begin
    btn_stable_d = btn_stable_q;
    btn_cnt_d    = btn_cnt_q;
    if (btn_sync_q == btn_stable_q) begin
      btn_cnt_d = '0;
    end else if (btn_cnt_q == CNT_MAX) begin
      btn_stable_d = btn_sync_q;
      btn_cnt_d    = '0;
    end else begin
      btn_cnt_d = btn_cnt_q + CNT_W'(1);
    end
  end

  // Edge detectors compare the debounced levels against their previous-cycle copies
  assign btn_rise = btn_stable_q & ~btn_prev_q;
  assign sw_chg   = (sw_stable_q != sw_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      btn_stable_q <= 1'b0;
      btn_cnt_q    <= '0;
      btn_prev_q   <= 1'b0;
      sw_prev_q    <= '0;
      state_q      <= DIRECT;
      idx_q        <= '0;
    end else begin
      btn_meta_q   <= btn;
      btn_sync_q   <= btn_meta_q;
      btn_stable_q <= btn_stable_d;
      btn_cnt_q    <= btn_cnt_d;
      btn_prev_q   <= btn_stable_q;
      sw_prev_q    <= sw_stable_q;
      state_q      <= state_d;
      idx_q        <= idx_d;
    end
  end

  // A switch change takes priority over a button press while cycling
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      DIRECT: begin
        if (btn_rise) begin
          state_d = CYCLE;
          idx_d   = sw_stable_q + 3'd1;
        end
      end
      CYCLE: begin
        if (sw_chg) begin
          state_d = DIRECT;
        end else if (btn_rise) begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = DIRECT;
    endcase
    colour_d = (state_d == CYCLE) ? idx_d : sw_stable_q;
  end

  assign mode_cycle = (state_q == CYCLE);
`else
  logic unused_btn;
  assign unused_btn = btn;

  always_comb begin
    colour_d = sw_stable_q;
  end

  assign mode_cycle = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_q <= '0;
    end else begin
      colour_q <= colour_d;
    end
  end

  assign red_out   = colour_q[2];
  assign green_out = colour_q[1];
  assign blue_out  = colour_q[0];

endmodule

// File: tb/tb_color_switch_ctrl.sv
// Directed bench for color_switch_ctrl with DEBOUNCE_CYCLES=4; cycling scenarios run when COLOR_CYCLE_EN is defined.
module tb_color_switch_ctrl;

  localparam int DC = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw;
  logic       btn;
  logic       red_out, green_out, blue_out, mode_cycle;

  int n_checks = 0;
  int n_fail   = 0;

  color_switch_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .btn        (btn),
    .red_out    (red_out),
    .green_out  (green_out),
    .blue_out   (blue_out),
    .mode_cycle (mode_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a new sw value; colour must hold prev through edge 6 and show nsw on edge 7.
  task automatic apply_sw(input logic [2:0] nsw, input logic [2:0] prev, input string name);
    logic [2:0] exp;
    @(negedge clk);
    sw = nsw;
    for (int k = 1; k <= DC + 3; k++) begin
      @(posedge clk); #1;
      exp = (k < DC + 3) ? prev : nsw;
      n_checks++;
      if ({red_out, green_out, blue_out} !== exp) begin
        n_fail++;
        $display("FAIL %s edge %0d: colour got %b expected %b", name, k, {red_out, green_out, blue_out}, exp);
      end
    end
  endtask

  task automatic test_reset();
    sw = 3'b000; btn = 1'b0; rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({red_out, green_out, blue_out, mode_cycle} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_async: outputs got %b expected 0000", {red_out, green_out, blue_out, mode_cycle});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      n_checks++;
      if ({red_out, green_out, blue_out, mode_cycle} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_idle: outputs got %b expected 0000", {red_out, green_out, blue_out, mode_cycle});
      end
    end
  endtask

  task automatic test_latency();
    apply_sw(3'b101, 3'b000, "latency_rise");
    apply_sw(3'b000, 3'b101, "latency_fall");
  endtask

  task automatic test_glitch();
    @(negedge clk);
    sw = 3'b010;
    repeat (DC - 1) @(negedge clk);
    sw = 3'b000;
    repeat (12) begin
      @(posedge clk); #1;
      n_checks++;
      if ({red_out, green_out, blue_out} !== 3'b000) begin
        n_fail++;
        $display("FAIL glitch: colour got %b expected 000", {red_out, green_out, blue_out});
      end
    end
  endtask

`ifdef COLOR_CYCLE_EN
  // Press btn (optionally changing sw at the same moment) and check the edge-6/edge-7 transition.
  task automatic press(input logic [2:0] nsw, input logic [2:0] old_c, input logic old_m,
                       input logic [2:0] new_c, input logic new_m, input string name);
    @(negedge clk);
    btn = 1'b1;
    sw  = nsw;
    for (int k = 1; k <= DC + 3; k++) begin
      @(posedge clk); #1;
      if (k == DC + 2) begin
        n_checks++;
        if ({red_out, green_out, blue_out, mode_cycle} !== {old_c, old_m}) begin
          n_fail++;
          $display("FAIL %s before: got %b expected %b", name, {red_out, green_out, blue_out, mode_cycle}, {old_c, old_m});
        end
      end
      if (k == DC + 3) begin
        n_checks++;
        if ({red_out, green_out, blue_out, mode_cycle} !== {new_c, new_m}) begin
          n_fail++;
          $display("FAIL %s after: got %b expected %b", name, {red_out, green_out, blue_out, mode_cycle}, {new_c, new_m});
        end
      end
    end
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if ({red_out, green_out, blue_out, mode_cycle} !== {new_c, new_m}) begin
      n_fail++;
      $display("FAIL %s release: got %b expected %b", name, {red_out, green_out, blue_out, mode_cycle}, {new_c, new_m});
    end
  endtask

  task automatic test_cycle();
    apply_sw(3'b110, 3'b000, "cycle_setup");
    press(3'b110, 3'b110, 1'b0, 3'b111, 1'b1, "cycle_p1");
    press(3'b110, 3'b111, 1'b1, 3'b000, 1'b1, "cycle_p2_wrap");
    press(3'b110, 3'b000, 1'b1, 3'b001, 1'b1, "cycle_p3");
    press(3'b110, 3'b001, 1'b1, 3'b010, 1'b1, "cycle_p4");
  endtask

  task automatic test_simultaneous();
    press(3'b011, 3'b010, 1'b1, 3'b011, 1'b0, "simul_in_cycle");
    press(3'b100, 3'b011, 1'b0, 3'b101, 1'b1, "simul_in_direct");
  endtask
`else
  task automatic test_btn_ignored();
    logic [2:0] pat [5] = '{3'b011, 3'b011, 3'b110, 3'b110, 3'b001};
    logic [2:0] cur;
    cur = sw;
    for (int i = 0; i < 5; i++) begin
      if (pat[i] != cur) begin
        apply_sw(pat[i], cur, "btn_off_sw");
        cur = pat[i];
      end
      @(negedge clk);
      btn = 1'b1;
      repeat (8) @(negedge clk);
      btn = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      n_checks++;
      if ({red_out, green_out, blue_out, mode_cycle} !== {cur, 1'b0}) begin
        n_fail++;
        $display("FAIL btn_off press %0d: got %b expected %b", i, {red_out, green_out, blue_out, mode_cycle}, {cur, 1'b0});
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
`ifdef COLOR_CYCLE_EN
    n_checks++;
    if (mode_cycle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_precond: mode_cycle got %b expected 1", mode_cycle);
    end
`endif
    @(negedge clk);
    sw = ~sw;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({red_out, green_out, blue_out, mode_cycle} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_async: outputs got %b expected 0000", {red_out, green_out, blue_out, mode_cycle});
    end
    sw = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= DC + 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({red_out, green_out, blue_out, mode_cycle} !== ((k < DC + 3) ? 4'b0000 : 4'b1110)) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got %b expected %b", k, {red_out, green_out, blue_out, mode_cycle},
                 ((k < DC + 3) ? 4'b0000 : 4'b1110));
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
`ifdef COLOR_CYCLE_EN
    test_cycle();
    test_simultaneous();
`else
    test_btn_ignored();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/color_switch_ctrl.md
COLOR_SWITCH_CTRL -- requirements
Module: color_switch_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, giving the number of consecutive cycles an input must hold a new level before it is accepted (10 ms at 25 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 18, giving the debounce counter width; 2^CNT_W SHALL be at least DEBOUNCE_CYCLES.
REQ-003 The block SHALL have port clk, input, 1 bit: the pixel clock, the same clock that drives the VGA timing stage.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sw, input, 3 bits: raw board switches, with [2]=red, [1]=green, [0]=blue.
REQ-006 The block SHALL have port btn, input, 1 bit: raw push-button, active-high.
REQ-007 The block SHALL have ports red_out, green_out and blue_out, each an output of 1 bit: registered colour bits that feed the VGA stage's red_in, green_in and blue_in.
REQ-008 The block SHALL have port mode_cycle, output, 1 bit: 1 while the FSM is in state CYCLE.

Function
REQ-009 Each of the four raw inputs SHALL pass through its own two-flop synchronizer before any other logic.
REQ-010 Each synchronized input SHALL have its own debouncer with a stable register and a CNT_W-bit counter.
- If the synchronized value equals stable, the counter clears to 0.
- If they differ, the counter increments.
- On the edge where the counter equals DEBOUNCE_CYCLES-1, stable takes the synchronized value and the counter clears.
REQ-011 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave stable unchanged, and SHALL restart the count from 0 when the input returns to the stable level.
REQ-012 The colour outputs SHALL be registered from the FSM result.
- Total latency from raw input to output is DEBOUNCE_CYCLES+3 rising edges, counting the first edge that samples the new raw level as edge 1.
REQ-013 btn_rise SHALL be a one-cycle pulse asserted when debounced btn goes from 0 to 1; releasing the button SHALL produce no event.
REQ-014 sw_chg SHALL be a one-cycle pulse asserted when any debounced sw bit changes.
REQ-015 The FSM SHALL have two states, DIRECT and CYCLE, and a 3-bit index register idx.
REQ-016 In DIRECT, the colour SHALL equal the debounced sw value; on btn_rise the FSM SHALL go to CYCLE and load idx with the debounced sw value plus 1, modulo 8.
REQ-017 In CYCLE, the colour SHALL equal idx.
- On btn_rise, idx increments, wrapping from 7 to 0.
- On sw_chg, the FSM goes to DIRECT.
REQ-018 If btn_rise and sw_chg occur in the same cycle while in CYCLE, sw_chg SHALL win: the FSM goes to DIRECT and idx is unchanged.
REQ-019 If btn_rise and sw_chg occur in the same cycle while in DIRECT, the FSM SHALL go to CYCLE using the newly debounced sw value.
REQ-020 The colour bits SHALL map as red_out=colour[2], green_out=colour[1], blue_out=colour[0].

Reset
REQ-021 While rst_n=0, all synchronizer flops, stable registers, counters and idx SHALL be 0, the state SHALL be DIRECT, and red_out, green_out, blue_out and mode_cycle SHALL be 0.
REQ-022 Reset asserted mid-debounce or while in CYCLE SHALL take effect immediately and discard any partial count.
REQ-023 After rst_n deasserts, switches held high at reset release SHALL appear at the outputs after the normal debounce latency.

Configuration
REQ-024 With macro COLOR_CYCLE_EN defined, the btn path and the CYCLE state SHALL be implemented as described under Function.
REQ-025 Without COLOR_CYCLE_EN, btn SHALL be ignored, no btn synchronizer or debouncer SHALL be built, the FSM SHALL remain in DIRECT, and mode_cycle SHALL be tied to 0.

Verification
REQ-026 The bench SHALL check basic latency: with DEBOUNCE_CYCLES=4 after reset, set sw=3'b101 -> red_out=1, green_out=0, blue_out=1 on edge 7 and not before.
REQ-027 The bench SHALL check glitch rejection: with DEBOUNCE_CYCLES=4 and sw=0, pulse sw[1] high for 3 cycles -> outputs stay 000 throughout.
REQ-028 The bench SHALL check cycling and wrap (COLOR_CYCLE_EN): with sw=3'b110 settled, give 3 clean btn presses -> colours 111, 000, 001 in sequence with mode_cycle=1.
REQ-029 The bench SHALL check simultaneous events: in CYCLE with idx=2, make debounced btn_rise and sw_chg coincide -> next cycle mode_cycle=0 and the colour equals the new sw value.
REQ-030 The bench SHALL check reset mid-operation: assert rst_n=0 in CYCLE partway through a debounce -> all outputs 0 asynchronously and the state is DIRECT after release.
REQ-031 The bench SHALL check the macro-off build: with COLOR_CYCLE_EN undefined, press btn 5 times -> mode_cycle stays 0 and the colour tracks sw only.
